// File: rtl/dcmac_port_reset_ctrl_if.sv
// Reset-control signal bundle between user logic / GT lanes and dcmac_port_reset_ctrl.
interface dcmac_port_reset_ctrl_if #(
    parameter int NUM_PORTS      = 2,
    parameter int LANES_PER_PORT = 4
);
    logic                                user_reset_all;
    logic [NUM_PORTS-1:0]                user_rx_reset;
    logic [NUM_PORTS*LANES_PER_PORT-1:0] gt_rx_reset_done;
    logic [NUM_PORTS*LANES_PER_PORT-1:0] gt_tx_reset_done;
    logic                                gt_reset_all_out;
    logic [NUM_PORTS-1:0]                gt_reset_rx_datapath;
    logic [NUM_PORTS-1:0]                axis_resetn;
    logic [NUM_PORTS-1:0]                port_ready;
    logic [NUM_PORTS-1:0]                port_failed;
    logic [4*NUM_PORTS-1:0]              retry_count;

    modport master (
        output user_reset_all, user_rx_reset, gt_rx_reset_done, gt_tx_reset_done,
        input  gt_reset_all_out, gt_reset_rx_datapath, axis_resetn, port_ready,
               port_failed, retry_count
    );

    modport slave (
        input  user_reset_all, user_rx_reset, gt_rx_reset_done, gt_tx_reset_done,
        output gt_reset_all_out, gt_reset_rx_datapath, axis_resetn, port_ready,
               port_failed, retry_count
    );
endinterface

// File: rtl/dcmac_port_reset_ctrl.sv
// Per-port DCMAC/GT reset sequencer: lane-done aggregation, settle qualification, RX recovery.
// Optional macro DCMAC_RESET_AUTO_RETRY_EN enables automatic recovery pulses and retry counting.
module dcmac_port_reset_ctrl #(
    parameter int NUM_PORTS      = 2,
    parameter int LANES_PER_PORT = 4,
    parameter int SYNC_STAGES    = 3,
    parameter int PULSE_CYCLES   = 16,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    dcmac_port_reset_ctrl_if.slave rst_if
);
    localparam int NL     = NUM_PORTS * LANES_PER_PORT;
    localparam int TMAX_I = (TIMEOUT_CYCLES > SETTLE_CYCLES)
                          ? ((TIMEOUT_CYCLES > PULSE_CYCLES) ? TIMEOUT_CYCLES : PULSE_CYCLES)
                          : ((SETTLE_CYCLES > PULSE_CYCLES) ? SETTLE_CYCLES : PULSE_CYCLES);
    localparam int TW     = $clog2(TMAX_I + 1);

    localparam logic [TW-1:0] TIMER_MAX    = TW'(TMAX_I);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] PULSE_LAST   = TW'(PULSE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

`ifdef DCMAC_RESET_AUTO_RETRY_EN
    localparam bit AUTO_RETRY = 1'b1;
`else
    localparam bit AUTO_RETRY = 1'b0;
`endif

    typedef enum logic [2:0] {
        WAIT_DONE = 3'd0,
        SETTLE    = 3'd1,
        READY     = 3'd2,
        PULSE     = 3'd3,
        FAILED    = 3'd4
    } state_e;

    logic [1:0]                  rst_sync_q;
    logic                        rst_n_s;
    logic [SYNC_STAGES*NL-1:0]   rx_sh_q;
    logic [SYNC_STAGES*NL-1:0]   tx_sh_q;
    logic [NL-1:0]               rx_sync_s;
    logic [NL-1:0]               tx_sync_s;
    logic [NUM_PORTS-1:0]        all_ok_s;
    logic [NUM_PORTS-1:0]        user_q;
    logic [NUM_PORTS-1:0]        rise_s;
    logic [NUM_PORTS-1:0]        clr_s;

    state_e                      state_q [NUM_PORTS];
    state_e                      state_d [NUM_PORTS];
    logic [NUM_PORTS-1:0][TW-1:0] timer_q;
    logic [NUM_PORTS-1:0][TW-1:0] timer_d;
    logic [NUM_PORTS-1:0][3:0]   retry_q;
    logic [NUM_PORTS-1:0][3:0]   retry_d;

    logic                        gt_all_q;
    logic [NUM_PORTS-1:0]        pulse_q;
    logic [NUM_PORTS-1:0]        axis_q;
    logic [NUM_PORTS-1:0]        ready_q;
    logic [NUM_PORTS-1:0]        failed_q;

    // Reset assertion is immediate; release is re-timed to clk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_q[1];

    // Synchroniser chains for the asynchronous lane done flags; newest stage at the low end.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            rx_sh_q <= '0;
            tx_sh_q <= '0;
        end else begin
            rx_sh_q <= {rx_sh_q[(SYNC_STAGES-1)*NL-1:0], rst_if.gt_rx_reset_done};
            tx_sh_q <= {tx_sh_q[(SYNC_STAGES-1)*NL-1:0], rst_if.gt_tx_reset_done};
        end
    end

    assign rx_sync_s = rx_sh_q[SYNC_STAGES*NL-1 -: NL];
    assign tx_sync_s = tx_sh_q[SYNC_STAGES*NL-1 -: NL];
    assign rise_s    = rst_if.user_rx_reset & ~user_q;

    // Per-port lane aggregation: a port is healthy only when every rx and tx lane is done.
    always_comb begin
        all_ok_s = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            all_ok_s[p] = (&rx_sync_s[p*LANES_PER_PORT +: LANES_PER_PORT])
                        & (&tx_sync_s[p*LANES_PER_PORT +: LANES_PER_PORT]);
        end
    end

    // Per-port next-state, timer and retry-count logic.
    always_comb begin
        clr_s = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            state_d[p] = state_q[p];
            retry_d[p] = retry_q[p];
            timer_d[p] = timer_q[p];
            if (rst_if.user_reset_all) begin
                state_d[p] = WAIT_DONE;
                retry_d[p] = 4'd0;
                clr_s[p]   = 1'b1;
            end else if (rise_s[p]) begin
                // A user request restarts the pulse even when already pulsing.
                state_d[p] = PULSE;
                retry_d[p] = 4'd0;
                clr_s[p]   = 1'b1;
            end else begin
                case (state_q[p])
                    WAIT_DONE: begin
                        if (all_ok_s[p]) begin
                            state_d[p] = SETTLE;
                        end else if (timer_q[p] == TIMEOUT_LAST) begin
                            if (AUTO_RETRY && (retry_q[p] < RETRY_LIMIT)) begin
                                state_d[p] = PULSE;
                                retry_d[p] = retry_q[p] + 4'd1;
                            end else begin
                                state_d[p] = FAILED;
                            end
                        end else begin
                            state_d[p] = WAIT_DONE;
                        end
                    end
                    SETTLE: begin
                        if (!all_ok_s[p]) begin
                            state_d[p] = WAIT_DONE;
                        end else if (timer_q[p] == SETTLE_LAST) begin
                            state_d[p] = READY;
                            retry_d[p] = 4'd0;
                        end else begin
                            state_d[p] = SETTLE;
                        end
                    end
                    READY: begin
                        if (!all_ok_s[p]) begin
                            if (AUTO_RETRY) begin
                                state_d[p] = PULSE;
                                retry_d[p] = (retry_q[p] == 4'hF) ? 4'hF : retry_q[p] + 4'd1;
                            end else begin
                                state_d[p] = WAIT_DONE;
                            end
                        end else begin
                            state_d[p] = READY;
                        end
                    end
                    PULSE: begin
                        if (timer_q[p] == PULSE_LAST) begin
                            state_d[p] = WAIT_DONE;
                        end else begin
                            state_d[p] = PULSE;
                        end
                    end
                    FAILED: begin
                        state_d[p] = FAILED;
                    end
                    default: begin
                        state_d[p] = WAIT_DONE;
                        clr_s[p]   = 1'b1;
                    end
                endcase
            end
            // Timer restarts on every state change and saturates instead of wrapping.
            if (clr_s[p] || (state_d[p] != state_q[p])) begin
                timer_d[p] = '0;
            end else if (timer_q[p] == TIMER_MAX) begin
                timer_d[p] = timer_q[p];
            end else begin
                timer_d[p] = timer_q[p] + TW'(1);
            end
        end
    end

    // FSM state, timer, retry and edge-detect registers.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                state_q[p] <= WAIT_DONE;
            end
            timer_q <= '0;
            retry_q <= '0;
            user_q  <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                state_q[p] <= state_d[p];
            end
            timer_q <= timer_d;
            retry_q <= retry_d;
            user_q  <= rst_if.user_rx_reset;
        end
    end

    // Output registers decoded from next state so they move together with the state.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            gt_all_q <= 1'b0;
            pulse_q  <= '0;
            axis_q   <= '0;
            ready_q  <= '0;
            failed_q <= '0;
        end else begin
            gt_all_q <= rst_if.user_reset_all;
            for (int p = 0; p < NUM_PORTS; p++) begin
                pulse_q[p]  <= (state_d[p] == PULSE);
                axis_q[p]   <= (state_d[p] == READY);
                ready_q[p]  <= (state_d[p] == READY);
                failed_q[p] <= (state_d[p] == FAILED);
            end
        end
    end

    assign rst_if.gt_reset_all_out     = gt_all_q;
    assign rst_if.gt_reset_rx_datapath = pulse_q;
    assign rst_if.axis_resetn          = axis_q;
    assign rst_if.port_ready           = ready_q;
    assign rst_if.port_failed          = failed_q;
    assign rst_if.retry_count          = retry_q;
endmodule

// File: tb/tb_dcmac_port_reset_ctrl.sv
// Directed self-checking bench for dcmac_port_reset_ctrl (honours DCMAC_RESET_AUTO_RETRY_EN).
module tb_dcmac_port_reset_ctrl;
    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;

    dcmac_port_reset_ctrl_if #(.NUM_PORTS(2), .LANES_PER_PORT(4)) ifc ();

    dcmac_port_reset_ctrl #(
        .NUM_PORTS(2), .LANES_PER_PORT(4), .SYNC_STAGES(3), .PULSE_CYCLES(4),
        .SETTLE_CYCLES(8), .TIMEOUT_CYCLES(100), .MAX_RETRIES(2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .rst_if (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        ifc.user_reset_all   = 1'b0;
        ifc.user_rx_reset    = 2'b00;
        ifc.gt_rx_reset_done = 8'h00;
        ifc.gt_tx_reset_done = 8'h00;
        tick(3);
        chk("rst_gt_all", 32'(ifc.gt_reset_all_out), 32'h0);
        chk("rst_axis",   32'(ifc.axis_resetn), 32'h0);
        chk("rst_ready",  32'(ifc.port_ready), 32'h0);
        chk("rst_failed", 32'(ifc.port_failed), 32'h0);
        chk("rst_retry",  32'(ifc.retry_count), 32'h0);
        chk("rst_pulse",  32'(ifc.gt_reset_rx_datapath), 32'h0);

        // Bring-up: all lanes done
        resetn = 1'b1;
        tick(4);
        chk("pre_ready", 32'(ifc.port_ready), 32'h0);
        ifc.gt_rx_reset_done = 8'hFF;
        ifc.gt_tx_reset_done = 8'hFF;
        tick(11);
        chk("bring_ready_early", 32'(ifc.port_ready), 32'h0);
        tick(1);
        chk("bring_ready", 32'(ifc.port_ready), 32'h3);
        chk("bring_axis",  32'(ifc.axis_resetn), 32'h3);
        chk("bring_retry", 32'(ifc.retry_count), 32'h0);

        // Global reset for 20 cycles, then a port 0 glitch during re-settle
        ifc.user_reset_all = 1'b1;
        tick(1);
        chk("gr_out_on",  32'(ifc.gt_reset_all_out), 32'h1);
        chk("gr_axis",    32'(ifc.axis_resetn), 32'h0);
        chk("gr_ready",   32'(ifc.port_ready), 32'h0);
        tick(19);
        chk("gr_out_hold", 32'(ifc.gt_reset_all_out), 32'h1);
        chk("gr_retry",    32'(ifc.retry_count), 32'h0);
        ifc.user_reset_all = 1'b0;
        tick(1);
        chk("gr_out_off", 32'(ifc.gt_reset_all_out), 32'h0);
        tick(3);
        ifc.gt_rx_reset_done[2] = 1'b0;
        tick(1);
        ifc.gt_rx_reset_done[2] = 1'b1;
        tick(3);
        chk("glitch_ready_d8", 32'(ifc.port_ready), 32'h0);
        tick(1);
        chk("glitch_ready_d9", 32'(ifc.port_ready), 32'h2);
        chk("glitch_axis_d9",  32'(ifc.axis_resetn), 32'h2);
        tick(7);
        chk("glitch_ready_d16", 32'(ifc.port_ready), 32'h2);
        tick(1);
        chk("glitch_ready_d17", 32'(ifc.port_ready), 32'h3);

        // Loss of port 0 tx lane 0 while READY
        ifc.gt_tx_reset_done[0] = 1'b0;
        tick(3);
        chk("loss_ready_l3", 32'(ifc.port_ready), 32'h3);
        tick(1);
        chk("loss_ready_l4", 32'(ifc.port_ready), 32'h2);
        ifc.gt_tx_reset_done[0] = 1'b1;
`ifdef DCMAC_RESET_AUTO_RETRY_EN
        chk("loss_pulse_l4", 32'(ifc.gt_reset_rx_datapath), 32'h1);
        chk("loss_retry_l4", 32'(ifc.retry_count), 32'h01);
        tick(3);
        chk("loss_pulse_l7", 32'(ifc.gt_reset_rx_datapath), 32'h1);
        tick(1);
        chk("loss_pulse_l8", 32'(ifc.gt_reset_rx_datapath), 32'h0);
        tick(8);
        chk("loss_ready_l16", 32'(ifc.port_ready), 32'h2);
        chk("loss_retry_l16", 32'(ifc.retry_count), 32'h01);
        tick(1);
        chk("loss_ready_l17", 32'(ifc.port_ready), 32'h3);
        chk("loss_retry_l17", 32'(ifc.retry_count), 32'h00);
`else
        chk("loss_pulse_l4", 32'(ifc.gt_reset_rx_datapath), 32'h0);
        chk("loss_retry_l4", 32'(ifc.retry_count), 32'h00);
        tick(4);
        chk("loss_pulse_l8", 32'(ifc.gt_reset_rx_datapath), 32'h0);
        chk("loss_ready_l8", 32'(ifc.port_ready), 32'h2);
        tick(7);
        chk("loss_ready_l15", 32'(ifc.port_ready), 32'h2);
        tick(1);
        chk("loss_ready_l16", 32'(ifc.port_ready), 32'h3);
        chk("loss_retry_l16", 32'(ifc.retry_count), 32'h00);
`endif

        // Port 1 never done: timeout handling from a clean WAIT_DONE
        ifc.user_reset_all = 1'b1;
        ifc.gt_rx_reset_done[7:4] = 4'h0;
        ifc.gt_tx_reset_done[7:4] = 4'h0;
        tick(5);
        ifc.user_reset_all = 1'b0;
        tick(1);
        chk("to_ready_d1", 32'(ifc.port_ready), 32'h0);
`ifdef DCMAC_RESET_AUTO_RETRY_EN
        tick(98);
        chk("to_pulse_d99", 32'(ifc.gt_reset_rx_datapath), 32'h0);
        chk("to_ready_d99", 32'(ifc.port_ready), 32'h1);
        tick(1);
        chk("to_pulse_d100", 32'(ifc.gt_reset_rx_datapath), 32'h2);
        chk("to_retry_d100", 32'(ifc.retry_count), 32'h10);
        tick(3);
        chk("to_pulse_d103", 32'(ifc.gt_reset_rx_datapath), 32'h2);
        tick(1);
        chk("to_pulse_d104", 32'(ifc.gt_reset_rx_datapath), 32'h0);
        tick(100);
        chk("to_pulse_d204", 32'(ifc.gt_reset_rx_datapath), 32'h2);
        chk("to_retry_d204", 32'(ifc.retry_count), 32'h20);
        tick(103);
        chk("to_failed_d307", 32'(ifc.port_failed), 32'h0);
        tick(1);
        chk("to_failed_d308", 32'(ifc.port_failed), 32'h2);
        chk("to_retry_d308",  32'(ifc.retry_count), 32'h20);
        chk("to_pulse_d308",  32'(ifc.gt_reset_rx_datapath), 32'h0);
        chk("to_axis_d308",   32'(ifc.axis_resetn), 32'h1);
`else
        tick(98);
        chk("to_failed_d99", 32'(ifc.port_failed), 32'h0);
        chk("to_ready_d99",  32'(ifc.port_ready), 32'h1);
        tick(1);
        chk("to_failed_d100", 32'(ifc.port_failed), 32'h2);
        chk("to_pulse_d100",  32'(ifc.gt_reset_rx_datapath), 32'h0);
        chk("to_retry_d100",  32'(ifc.retry_count), 32'h00);
        chk("to_axis_d100",   32'(ifc.axis_resetn), 32'h1);
`endif

        // User RX reset request recovers the failed port
        ifc.user_rx_reset[1] = 1'b1;
        tick(1);
        chk("usr_pulse_u1",  32'(ifc.gt_reset_rx_datapath), 32'h2);
        chk("usr_failed_u1", 32'(ifc.port_failed), 32'h0);
        chk("usr_retry_u1",  32'(ifc.retry_count), 32'h00);
        ifc.user_rx_reset[1] = 1'b0;
        tick(3);
        chk("usr_pulse_u4", 32'(ifc.gt_reset_rx_datapath), 32'h2);
        tick(1);
        chk("usr_pulse_u5", 32'(ifc.gt_reset_rx_datapath), 32'h0);
        chk("usr_ready_u5", 32'(ifc.port_ready), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
